// File: rtl/ddr_responder.sv
// ddr_responder: single-port DDR-side memory responder with programmable latency.
// Optional latency jitter (8-bit LFSR) is compiled in when DDR_RESP_JITTER_EN is defined.
module ddr_responder #(
  parameter int unsigned MEM_DEPTH = 4096,
  parameter int unsigned LATENCY   = 4,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         ddr_chip_enable,
  input  logic [18:0]  ddr_index,
  input  logic         ddr_write_enable,
  input  logic         ddr_burst_mode,
  input  logic [63:0]  ddr_opstore_write_mask,
  input  logic [63:0]  ddr_opstore_write_data,
  output logic [63:0]  ddr_opload_read_data,
  output logic [511:0] ddr_pc_read_inst,
  output logic         ddr_operation_done,
  output logic         ddr_ready
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] BASE_WAIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT, S_DONE} state_e;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_BURST} op_e;

  state_e         state_q, state_d;
  op_e            op_q, op_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [63:0]    mask_q, mask_d;
  logic [63:0]    wdata_q, wdata_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     beat_q, beat_d;
  logic [511:0]   buf_q, buf_d;
  logic [63:0]    opload_q, opload_d;
  logic [511:0]   inst_q, inst_d;

  logic [63:0]    mem [MEM_DEPTH];
  logic [AW-1:0]  rd_addr;
  logic [63:0]    rd_word;
  logic           accept;
  logic           enter_done;
  logic           commit_en;
  logic [CW-1:0]  wait_total;
  logic           unused_index_hi;

  assign unused_index_hi = ^ddr_index[18:AW];
  assign accept          = ddr_chip_enable && (state_q == S_IDLE);

`ifdef DDR_RESP_JITTER_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 8,6,5,4; the pre-advance value sets this request's extra wait.
  always_comb begin
    lfsr_d = lfsr_q;
    if (accept) lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign wait_total = BASE_WAIT + CW'(lfsr_q[2:0]);
`else
  assign wait_total = BASE_WAIT;
`endif

  // Request capture kept apart from the FSM so the memory address can follow it without a comb loop.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    op_d    = op_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    wdata_d = wdata_q;
    if (accept) begin
      if (ddr_burst_mode) begin
        op_d   = OP_BURST;
        addr_d = {ddr_index[AW-1:3], 3'b000};
      end else begin
        op_d   = ddr_write_enable ? OP_WRITE : OP_READ;
        addr_d = ddr_index[AW-1:0];
      end
      mask_d  = ddr_opstore_write_mask;
      wdata_d = ddr_opstore_write_data;
    end
  end

  assign rd_addr = (state_q == S_BEAT) ? {addr_q[AW-1:3], beat_q} : addr_d;
  assign rd_word = mem[rd_addr];

  // The counter holds the remaining WAIT cycles; LATENCY-1 of them leaves room for the DONE cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    beat_d   = beat_q;
    buf_d    = buf_q;
    opload_d = opload_q;
    inst_d   = inst_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d  = wait_total;
          beat_d = '0;
          if (wait_total != '0)      state_d = S_WAIT;
          else if (op_d == OP_BURST) state_d = S_BEAT;
          else                       state_d = S_DONE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = (op_q == OP_BURST) ? S_BEAT : S_DONE;
      end
      S_BEAT: begin
        buf_d[{beat_q, 6'd0} +: 64] = rd_word;
        beat_d = beat_q + 3'd1;
        if (beat_q == 3'd7) begin
          state_d = S_DONE;
          inst_d  = buf_d;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    enter_done = (state_d == S_DONE) && (state_q != S_DONE);
    if (enter_done && (op_d == OP_READ)) opload_d = rd_word;
  end

  assign commit_en = enter_done && (op_d == OP_WRITE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_READ;
      addr_q   <= '0;
      mask_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      beat_q   <= '0;
      buf_q    <= '0;
      opload_q <= '0;
      inst_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      mask_q   <= mask_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      buf_q    <= buf_d;
      opload_q <= opload_d;
      inst_q   <= inst_d;
    end
  end

  // NOTE: the memory array has no reset; an aborted write never commits because commit_en
  // is derived from state that reset forces back to IDLE.
  always_ff @(posedge clock) begin
    if (commit_en) mem[rd_addr] <= (rd_word & ~mask_d) | (wdata_d & mask_d);
  end

  assign ddr_opload_read_data = opload_q;
  assign ddr_pc_read_inst     = inst_q;
  assign ddr_operation_done   = (state_q == S_DONE);
  assign ddr_ready            = (state_q == S_IDLE);

endmodule

// File: tb/tb_ddr_responder.sv
// Self-checking bench for ddr_responder: directed scenarios plus randomized ops
// checked against an array-based reference model of the memory and response timing.
module tb_ddr_responder;
  localparam int LAT   = 4;
  localparam int DEPTH = 4096;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         ddr_chip_enable;
  logic [18:0]  ddr_index;
  logic         ddr_write_enable;
  logic         ddr_burst_mode;
  logic [63:0]  ddr_opstore_write_mask;
  logic [63:0]  ddr_opstore_write_data;
  logic [63:0]  ddr_opload_read_data;
  logic [511:0] ddr_pc_read_inst;
  logic         ddr_operation_done;
  logic         ddr_ready;

  int total = 0;
  int bad   = 0;

  logic [63:0]  model_mem [DEPTH];
  logic [63:0]  exp_opload;
  logic [511:0] exp_inst;

  always #5 clock = ~clock;

  ddr_responder #(.MEM_DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .ddr_chip_enable        (ddr_chip_enable),
    .ddr_index              (ddr_index),
    .ddr_write_enable       (ddr_write_enable),
    .ddr_burst_mode         (ddr_burst_mode),
    .ddr_opstore_write_mask (ddr_opstore_write_mask),
    .ddr_opstore_write_data (ddr_opstore_write_data),
    .ddr_opload_read_data   (ddr_opload_read_data),
    .ddr_pc_read_inst       (ddr_pc_read_inst),
    .ddr_operation_done     (ddr_operation_done),
    .ddr_ready              (ddr_ready)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Issues one request (waiting for ready), updates the model, returns cycles from accept to done.
  task automatic issue(input logic we, input logic burst, input logic [18:0] idx,
                       input logic [63:0] m, input logic [63:0] d,
                       output int lat, output logic [63:0] rd, output logic [511:0] inst,
                       output logic rdy_after, output logic done_after);
    int a;
    int base;
    for (int w = 0; w < 50 && ddr_ready !== 1'b1; w++) begin
      @(posedge clock); #1;
    end
    a = int'(idx) % DEPTH;
    if (burst) begin
      base = (int'(idx) / 8 * 8) % DEPTH;
      for (int k = 0; k < 8; k++) exp_inst[64*k +: 64] = model_mem[(base + k) % DEPTH];
    end else if (we) begin
      model_mem[a] = (model_mem[a] & ~m) | (d & m);
    end else begin
      exp_opload = model_mem[a];
    end
    ddr_chip_enable        = 1'b1;
    ddr_index              = idx;
    ddr_write_enable       = we;
    ddr_burst_mode         = burst;
    ddr_opstore_write_mask = m;
    ddr_opstore_write_data = d;
    @(posedge clock); #1;
    ddr_chip_enable = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      if (ddr_operation_done === 1'b1) begin
        lat = k;
        break;
      end
      @(posedge clock); #1;
    end
    rd   = ddr_opload_read_data;
    inst = ddr_pc_read_inst;
    @(posedge clock); #1;
    rdy_after  = ddr_ready;
    done_after = ddr_operation_done;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ddr_chip_enable = 1'b0; ddr_index = '0; ddr_write_enable = 1'b0; ddr_burst_mode = 1'b0;
    ddr_opstore_write_mask = '0; ddr_opstore_write_data = '0;
    exp_opload = '0; exp_inst = '0;
    repeat (2) @(posedge clock);
    #1;
    total++; if (ddr_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", ddr_ready); end
    total++; if (ddr_operation_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", ddr_operation_done); end
    total++; if (ddr_opload_read_data !== 64'h0) begin bad++; $display("FAIL rst_opload got=%h want=0", ddr_opload_read_data); end
    total++; if (ddr_pc_read_inst !== 512'h0) begin bad++; $display("FAIL rst_inst got=%h want=0", ddr_pc_read_inst); end
    reset_n = 1'b1;
    @(posedge clock); #1;
    total++; if (ddr_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b want=1", ddr_ready); end
  endtask

  task automatic test_write_read();
    int lat; logic [63:0] rd; logic [511:0] inst; logic ra, da;
    issue(1'b1, 1'b0, 19'h10, '1, 64'h1122334455667788, lat, rd, inst, ra, da);
    total++; if (lat !== LAT) begin bad++; $display("FAIL wr_latency got=%0d want=%0d", lat, LAT); end
    total++; if (ra !== 1'b1) begin bad++; $display("FAIL wr_ready_after got=%b want=1", ra); end
    total++; if (da !== 1'b0) begin bad++; $display("FAIL wr_done_width got=%b want=0", da); end
    total++; if (rd !== 64'h0) begin bad++; $display("FAIL wr_opload_untouched got=%h want=0", rd); end
    issue(1'b0, 1'b0, 19'h10, '0, '0, lat, rd, inst, ra, da);
    total++; if (lat !== LAT) begin bad++; $display("FAIL rd_latency got=%0d want=%0d", lat, LAT); end
    total++; if (rd !== 64'h1122334455667788) begin bad++; $display("FAIL rd_data got=%h want=1122334455667788", rd); end
  endtask

  task automatic test_masked_write();
    int lat; logic [63:0] rd; logic [511:0] inst; logic ra, da;
    issue(1'b1, 1'b0, 19'h20, '1, 64'hFFFFFFFFFFFFFFFF, lat, rd, inst, ra, da);
    issue(1'b1, 1'b0, 19'h20, 64'h00000000FFFF0000, 64'h0, lat, rd, inst, ra, da);
    total++; if (rd !== 64'h1122334455667788) begin bad++; $display("FAIL mw_opload_held got=%h want=1122334455667788", rd); end
    issue(1'b0, 1'b0, 19'h20, '0, '0, lat, rd, inst, ra, da);
    total++; if (rd !== 64'hFFFFFFFF0000FFFF) begin bad++; $display("FAIL mw_data got=%h want=ffffffff0000ffff", rd); end
  endtask

  task automatic test_burst();
    int lat; logic [63:0] rd; logic [511:0] inst; logic ra, da;
    logic [511:0] want;
    for (int k = 0; k < 8; k++) begin
      issue(1'b1, 1'b0, 19'(32'h40 + k), '1, 64'(k), lat, rd, inst, ra, da);
      want[64*k +: 64] = 64'(k);
    end
    issue(1'b0, 1'b1, 19'h45, '0, '0, lat, rd, inst, ra, da);
    total++; if (lat !== LAT + 8) begin bad++; $display("FAIL burst_latency got=%0d want=%0d", lat, LAT + 8); end
    total++; if (inst !== want) begin bad++; $display("FAIL burst_data got=%h want=%h", inst, want); end
    total++; if (rd !== 64'hFFFFFFFF0000FFFF) begin bad++; $display("FAIL burst_opload_held got=%h want=ffffffff0000ffff", rd); end
  endtask

  task automatic test_busy();
    int lat; logic [63:0] rd; logic [511:0] inst; logic ra, da;
    logic [63:0] va, vb, first_rd;
    int dones, first_k, early_rdy;
    logic rdy_at_end;
    va = {$urandom, $urandom};
    vb = {$urandom, $urandom};
    issue(1'b1, 1'b0, 19'h50, '1, va, lat, rd, inst, ra, da);
    issue(1'b1, 1'b0, 19'h51, '1, vb, lat, rd, inst, ra, da);
    ddr_chip_enable = 1'b1; ddr_write_enable = 1'b0; ddr_burst_mode = 1'b0; ddr_index = 19'h50;
    @(posedge clock); #1;
    ddr_index = 19'h51;
    dones = 0; first_k = -1; early_rdy = 0; first_rd = '0; rdy_at_end = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      if (ddr_operation_done === 1'b1) begin
        dones++;
        if (first_k < 0) begin first_k = k; first_rd = ddr_opload_read_data; end
      end
      if (k <= LAT && ddr_ready !== 1'b0) early_rdy++;
      if (k == LAT + 1) rdy_at_end = ddr_ready;
      else begin @(posedge clock); #1; end
    end
    // The held strobe is taken on the edge that ends the first ready cycle.
    @(posedge clock); #1;
    ddr_chip_enable = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      if (ddr_operation_done === 1'b1) begin lat = k; break; end
      @(posedge clock); #1;
    end
    rd = ddr_opload_read_data;
    exp_opload = vb;
    @(posedge clock); #1;
    total++; if (first_k !== LAT) begin bad++; $display("FAIL busy_first_latency got=%0d want=%0d", first_k, LAT); end
    total++; if (first_rd !== va) begin bad++; $display("FAIL busy_first_data got=%h want=%h", first_rd, va); end
    total++; if (dones !== 1) begin bad++; $display("FAIL busy_done_count got=%0d want=1", dones); end
    total++; if (early_rdy !== 0) begin bad++; $display("FAIL busy_ready_low got=%0d want=0", early_rdy); end
    total++; if (rdy_at_end !== 1'b1) begin bad++; $display("FAIL busy_ready_return got=%b want=1", rdy_at_end); end
    total++; if (lat !== LAT) begin bad++; $display("FAIL busy_second_latency got=%0d want=%0d", lat, LAT); end
    total++; if (rd !== vb) begin bad++; $display("FAIL busy_second_data got=%h want=%h", rd, vb); end
  endtask

  task automatic test_reset_mid_write();
    int lat; logic [63:0] rd; logic [511:0] inst; logic ra, da;
    int dones;
    issue(1'b1, 1'b0, 19'h30, '1, 64'hCAFEF00D12345678, lat, rd, inst, ra, da);
    ddr_chip_enable = 1'b1; ddr_write_enable = 1'b1; ddr_burst_mode = 1'b0; ddr_index = 19'h30;
    ddr_opstore_write_mask = '1; ddr_opstore_write_data = 64'hDEADBEEFDEADBEEF;
    @(posedge clock); #1;
    ddr_chip_enable = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    exp_opload = '0; exp_inst = '0;
    total++; if (ddr_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", ddr_ready); end
    total++; if (ddr_operation_done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", ddr_operation_done); end
    total++; if (ddr_opload_read_data !== 64'h0) begin bad++; $display("FAIL midrst_opload got=%h want=0", ddr_opload_read_data); end
    total++; if (ddr_pc_read_inst !== 512'h0) begin bad++; $display("FAIL midrst_inst got=%h want=0", ddr_pc_read_inst); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    dones = 0;
    for (int k = 0; k < LAT + 4; k++) begin
      if (ddr_operation_done === 1'b1) dones++;
      @(posedge clock); #1;
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d want=0", dones); end
    issue(1'b0, 1'b0, 19'h30, '0, '0, lat, rd, inst, ra, da);
    total++; if (rd !== 64'hCAFEF00D12345678) begin bad++; $display("FAIL midrst_old_value got=%h want=cafef00d12345678", rd); end
  endtask

  task automatic test_wrap();
    int lat; logic [63:0] rd; logic [511:0] inst; logic ra, da;
    logic [63:0] v;
    v = {$urandom, $urandom};
    issue(1'b1, 1'b0, 19'h01005, '1, v, lat, rd, inst, ra, da);
    issue(1'b0, 1'b0, 19'h00005, '0, '0, lat, rd, inst, ra, da);
    total++; if (rd !== v) begin bad++; $display("FAIL wrap_low got=%h want=%h", rd, v); end
    issue(1'b0, 1'b0, 19'h7F005, '0, '0, lat, rd, inst, ra, da);
    total++; if (rd !== v) begin bad++; $display("FAIL wrap_high got=%h want=%h", rd, v); end
  endtask

  task automatic test_random();
    int lat; logic [63:0] rd; logic [511:0] inst; logic ra, da;
    int kind, want_lat;
    logic [18:0] idx;
    logic [63:0] m, d;
    for (int k = 0; k < 64; k++)
      issue(1'b1, 1'b0, 19'(32'h200 + k), '1, {$urandom, $urandom}, lat, rd, inst, ra, da);
    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 2));
      idx  = 19'(($urandom_range(0, 127) << 12) | (32'h200 + $urandom_range(0, 63)));
      m    = {$urandom, $urandom};
      d    = {$urandom, $urandom};
      want_lat = (kind == 2) ? LAT + 8 : LAT;
      issue(kind == 1, kind == 2, idx, m, d, lat, rd, inst, ra, da);
      total++; if (lat !== want_lat) begin bad++; $display("FAIL rnd_latency n=%0d got=%0d want=%0d", n, lat, want_lat); end
      total++; if (rd !== exp_opload) begin bad++; $display("FAIL rnd_opload n=%0d got=%h want=%h", n, rd, exp_opload); end
      total++; if (inst !== exp_inst) begin bad++; $display("FAIL rnd_inst n=%0d got=%h want=%h", n, inst, exp_inst); end
      total++; if (ra !== 1'b1 || da !== 1'b0) begin bad++; $display("FAIL rnd_handshake n=%0d got=%b%b want=10", n, ra, da); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_masked_write();
    test_burst();
    test_busy();
    test_reset_mid_write();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
